// File: rtl/id_stage_pkg.sv
// Shared decode definitions for the instruction-decode stage: opcodes,
// instruction field positions, immediate-extension modes and the ID/EX record.
package id_defs;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_LB    = 6'h20;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;

  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 26;
  localparam int RS_MSB  = 25;
  localparam int RS_LSB  = 21;
  localparam int RT_MSB  = 20;
  localparam int RT_LSB  = 16;
  localparam int RD_MSB  = 15;
  localparam int RD_LSB  = 11;
  localparam int IMM_MSB = 15;
  localparam int IMM_LSB = 0;
  localparam int FN_MSB  = 5;
  localparam int FN_LSB  = 0;

  typedef enum logic [1:0] {
    IMM_SIGN = 2'd0,
    IMM_ZERO = 2'd1,
    IMM_LUI  = 2'd2
  } imm_mode_e;

  typedef struct packed {
    logic        valid;
    logic [5:0]  opcode;
    logic [5:0]  func;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
    logic [4:0]  wr_addr;
    logic        wr_en;
    logic        mem_read;
  } idex_t;

endpackage

// File: rtl/id_stage_imm_ext.sv
// 16-to-32-bit immediate extension: sign-extend, zero-extend or lui placement.
module imm_ext
  import id_defs::*;
(
  input  logic [15:0] i_imm,
  input  imm_mode_e   i_mode,
  output logic [31:0] o_imm
);

  always_comb begin
    o_imm = {{16{i_imm[15]}}, i_imm};
    case (i_mode)
      IMM_ZERO: o_imm = {16'h0000, i_imm};
      IMM_LUI:  o_imm = {i_imm, 16'h0000};
      default:  o_imm = {{16{i_imm[15]}}, i_imm};
    endcase
  end

endmodule

// File: rtl/id_stage.sv
// MIPS instruction-decode stage: field split, reg_file read with write-back
// bypass, load-use hazard detection and the ID/EX pipeline register.
module id_stage
  import id_defs::*;
#(
  parameter bit BYPASS_EN = 1'b1
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic [31:0] Instr,
  input  logic        InstrValid,
  output logic        IdStall,
  output logic [4:0]  Ard1,
  output logic [4:0]  Ard2,
  input  logic [31:0] Dout1,
  input  logic [31:0] Dout2,
  input  logic [4:0]  WbAwr,
  input  logic [31:0] WbDin,
  input  logic        WbWrEn,
  input  logic        ExStall,
  input  logic        Flush,
  output logic        ExValid,
  output logic [5:0]  ExOpcode,
  output logic [5:0]  ExFunc,
  output logic [31:0] ExA,
  output logic [31:0] ExB,
  output logic [31:0] ExImm,
  output logic [4:0]  ExWrAddr,
  output logic        ExWrEn,
  output logic        ExMemRead
);

  // Fetch handshake: Instr is consumed at a rising edge where IdStall is low
  // (InstrValid marks it real); while IdStall is high fetch holds Instr stable.

  logic [5:0]  w_opcode;
  logic [4:0]  w_rs;
  logic [4:0]  w_rt;
  logic [4:0]  w_rd;
  logic [5:0]  w_func;
  logic [15:0] w_imm16;
  logic [31:0] w_imm32;
  logic [4:0]  w_wr_addr;
  logic        w_wr_en;
  logic        w_mem_read;
  logic        w_uses_rt;
  imm_mode_e   w_imm_mode;
  logic        w_byp1;
  logic        w_byp2;
  logic [31:0] w_a;
  logic [31:0] w_b;
  logic        w_hz;
  idex_t       r_ex;
  idex_t       w_ex_dec;

  assign w_opcode = Instr[OPC_MSB:OPC_LSB];
  assign w_rs     = Instr[RS_MSB:RS_LSB];
  assign w_rt     = Instr[RT_MSB:RT_LSB];
  assign w_rd     = Instr[RD_MSB:RD_LSB];
  assign w_func   = Instr[FN_MSB:FN_LSB];
  assign w_imm16  = Instr[IMM_MSB:IMM_LSB];

  assign Ard1 = w_rs;
  assign Ard2 = w_rt;

  always_comb begin
    w_wr_addr  = w_rt;
    w_wr_en    = 1'b1;
    w_mem_read = 1'b0;
    w_uses_rt  = 1'b0;
    w_imm_mode = IMM_SIGN;
    case (w_opcode)
      OP_RTYPE: begin
        w_wr_addr = w_rd;
        w_uses_rt = 1'b1;
      end
      OP_LW, OP_LB: w_mem_read = 1'b1;
      OP_SW, OP_BEQ, OP_BNE: begin
        w_wr_en   = 1'b0;
        w_uses_rt = 1'b1;
      end
      OP_ANDI, OP_ORI: w_imm_mode = IMM_ZERO;
      OP_LUI:          w_imm_mode = IMM_LUI;
      default: ;
    endcase
    // r0 is hardwired to zero, so a write to it is not a write at all.
    if (w_wr_addr == 5'd0) w_wr_en = 1'b0;
  end

  imm_ext u_imm_ext (
    .i_imm  (w_imm16),
    .i_mode (w_imm_mode),
    .o_imm  (w_imm32)
  );

  // reg_file commits write-back at the same edge we capture, so forward it.
  assign w_byp1 = BYPASS_EN && WbWrEn && (WbAwr != 5'd0) && (WbAwr == w_rs);
  assign w_byp2 = BYPASS_EN && WbWrEn && (WbAwr != 5'd0) && (WbAwr == w_rt);
  assign w_a    = w_byp1 ? WbDin : Dout1;
  assign w_b    = w_byp2 ? WbDin : Dout2;

  assign w_hz = InstrValid && r_ex.valid && r_ex.mem_read && (r_ex.wr_addr != 5'd0) &&
                ((r_ex.wr_addr == w_rs) || (w_uses_rt && (r_ex.wr_addr == w_rt)));

  assign IdStall = Rst_n && (ExStall || w_hz);

  always_comb begin
    w_ex_dec.valid    = InstrValid;
    w_ex_dec.opcode   = w_opcode;
    w_ex_dec.func     = w_func;
    w_ex_dec.a        = w_a;
    w_ex_dec.b        = w_b;
    w_ex_dec.imm      = w_imm32;
    w_ex_dec.wr_addr  = w_wr_addr;
    w_ex_dec.wr_en    = w_wr_en && InstrValid;
    w_ex_dec.mem_read = w_mem_read && InstrValid;
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_ex <= '0;
    end else if (Flush || (!ExStall && w_hz)) begin
      // Flush and bubble both kill only the control bits; data fields linger.
      r_ex.valid    <= 1'b0;
      r_ex.wr_en    <= 1'b0;
      r_ex.mem_read <= 1'b0;
    end else if (!ExStall) begin
      r_ex <= w_ex_dec;
    end
  end

  assign ExValid   = r_ex.valid;
  assign ExOpcode  = r_ex.opcode;
  assign ExFunc    = r_ex.func;
  assign ExA       = r_ex.a;
  assign ExB       = r_ex.b;
  assign ExImm     = r_ex.imm;
  assign ExWrAddr  = r_ex.wr_addr;
  assign ExWrEn    = r_ex.wr_en;
  assign ExMemRead = r_ex.mem_read;

endmodule

// File: tb/tb_id_stage.sv
// Directed and randomised bench for id_stage with a reg_file model and an
// expected-queue scoreboard of ID/EX contents.
module tb_id_stage;

  typedef struct packed {
    logic        valid;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
    logic [4:0]  wa;
    logic        we;
    logic        mr;
  } ex_t;
  localparam int EXW = $bits(ex_t);

  logic        Clk = 1'b0;
  logic        Rst_n;
  logic [31:0] Instr;
  logic        InstrValid;
  logic        IdStall;
  logic [4:0]  Ard1, Ard2;
  logic [31:0] Dout1, Dout2;
  logic [4:0]  WbAwr;
  logic [31:0] WbDin;
  logic        WbWrEn;
  logic        ExStall, Flush;
  logic        ExValid;
  logic [5:0]  ExOpcode, ExFunc;
  logic [31:0] ExA, ExB, ExImm;
  logic [4:0]  ExWrAddr;
  logic        ExWrEn, ExMemRead;

  logic [31:0]    rf [32];
  logic [EXW-1:0] exp_q [$];
  ex_t            m;
  int             errors = 0;
  int             checks = 0;

  // ---------------- clock / reset ----------------
  always #5 Clk = ~Clk;

  assign Dout1 = rf[Ard1];
  assign Dout2 = rf[Ard2];

  id_stage #(.BYPASS_EN(1'b1)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Instr(Instr), .InstrValid(InstrValid),
    .IdStall(IdStall), .Ard1(Ard1), .Ard2(Ard2), .Dout1(Dout1), .Dout2(Dout2),
    .WbAwr(WbAwr), .WbDin(WbDin), .WbWrEn(WbWrEn), .ExStall(ExStall), .Flush(Flush),
    .ExValid(ExValid), .ExOpcode(ExOpcode), .ExFunc(ExFunc), .ExA(ExA), .ExB(ExB),
    .ExImm(ExImm), .ExWrAddr(ExWrAddr), .ExWrEn(ExWrEn), .ExMemRead(ExMemRead)
  );

  // ---------------- encoders ----------------
  function automatic logic [31:0] r_ins(logic [4:0] rs, logic [4:0] rt, logic [4:0] rd, logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] i_ins(logic [5:0] op, logic [4:0] rs, logic [4:0] rt, logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  // ---------------- reference model ----------------
  function automatic logic model_hz();
    logic [5:0] op;
    logic [4:0] rs, rt;
    logic       uses_rt;
    op = Instr[31:26];
    rs = Instr[25:21];
    rt = Instr[20:16];
    uses_rt = (op == 6'h00) || (op == 6'h2B) || (op == 6'h04) || (op == 6'h05);
    return InstrValid && m.valid && m.mr && (m.wa != 0) &&
           ((m.wa == rs) || (uses_rt && (m.wa == rt)));
  endfunction

  function automatic ex_t model_next();
    ex_t        n;
    logic [5:0] op;
    logic [4:0] rs, rt;
    logic [15:0] im;
    n  = m;
    op = Instr[31:26];
    rs = Instr[25:21];
    rt = Instr[20:16];
    im = Instr[15:0];
    if (Flush || (!ExStall && model_hz())) begin
      n.valid = 1'b0;
      n.we    = 1'b0;
      n.mr    = 1'b0;
    end else if (!ExStall) begin
      n.valid = InstrValid;
      n.op    = op;
      n.fn    = Instr[5:0];
      n.a     = (WbWrEn && WbAwr != 0 && WbAwr == rs) ? WbDin : rf[rs];
      n.b     = (WbWrEn && WbAwr != 0 && WbAwr == rt) ? WbDin : rf[rt];
      if (op == 6'h0C || op == 6'h0D) n.imm = {16'h0, im};
      else if (op == 6'h0F)           n.imm = {im, 16'h0};
      else                            n.imm = {{16{im[15]}}, im};
      n.wa = (op == 6'h00) ? Instr[15:11] : rt;
      n.we = !(op == 6'h2B || op == 6'h04 || op == 6'h05) && (n.wa != 0) && InstrValid;
      n.mr = (op == 6'h23 || op == 6'h20) && InstrValid;
    end
    return n;
  endfunction

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [EXW-1:0] obs, input logic [EXW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic ex_t ex_obs();
    return {ExValid, ExOpcode, ExFunc, ExA, ExB, ExImm, ExWrAddr, ExWrEn, ExMemRead};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [31:0] ins, input logic v, input logic st, input logic fl);
    Instr = ins; InstrValid = v; ExStall = st; Flush = fl;
  endtask

  task automatic wb(input logic en, input logic [4:0] a, input logic [31:0] d);
    WbWrEn = en; WbAwr = a; WbDin = d;
  endtask

  // One clock: check IdStall, push expected ID/EX, clock, pop and compare.
  task automatic cycle(input string tag);
    ex_t e;
    #1;
    chk({tag, "_idstall"}, EXW'(IdStall), EXW'(ExStall || model_hz()));
    exp_q.push_back(model_next());
    @(posedge Clk);
    #1;
    if (WbWrEn && WbAwr != 0) rf[WbAwr] = WbDin;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL %s_queue observed=empty expected=entry", tag);
    end else begin
      e = ex_t'(exp_q.pop_front());
      chk(tag, ex_obs(), e);
      m = e;
    end
  endtask

  // ---------------- stimulus ----------------
  logic [5:0] op_tab [10];

  initial begin
    op_tab = '{6'h00, 6'h23, 6'h20, 6'h2B, 6'h04, 6'h05, 6'h0C, 6'h0D, 6'h0F, 6'h08};
    for (int i = 0; i < 32; i++) rf[i] = (i == 0) ? 32'h0 : $urandom;
    m = '0;
    wb(1'b0, 5'd0, 32'h0);

    // 1. reset: Ex* zero and IdStall forced low even with ExStall high
    Rst_n = 1'b0;
    drive(r_ins(5'd1, 5'd2, 5'd3, 6'h20), 1'b1, 1'b1, 1'b0);
    #12;
    chk("reset_ex", ex_obs(), '0);
    chk("reset_idstall", EXW'(IdStall), '0);
    chk("ard1", EXW'(Ard1), EXW'(5'd1));
    chk("ard2", EXW'(Ard2), EXW'(5'd2));
    ExStall = 1'b0;
    Rst_n   = 1'b1;
    cycle("add_first");
    chk("add_a", EXW'(ExA), EXW'(rf[1]));
    chk("add_wa", EXW'(ExWrAddr), EXW'(5'd3));

    // 2. bypass from write-back, then r0 write-back is not forwarded
    drive(i_ins(6'h08, 5'd10, 5'd11, 16'h0005), 1'b1, 1'b0, 1'b0);
    wb(1'b1, 5'd10, 32'h2);
    cycle("byp_rs");
    chk("byp_a", EXW'(ExA), EXW'(32'h2));
    drive(i_ins(6'h08, 5'd0, 5'd12, 16'h0007), 1'b1, 1'b0, 1'b0);
    wb(1'b1, 5'd0, 32'hDEAD_BEEF);
    cycle("byp_r0");
    chk("byp_r0_a", EXW'(ExA), '0);
    drive(r_ins(5'd13, 5'd14, 5'd15, 6'h22), 1'b1, 1'b0, 1'b0);
    wb(1'b1, 5'd14, 32'h1234_5678);
    cycle("byp_rt");
    wb(1'b0, 5'd0, 32'h0);

    // 3. load-use: one stall cycle, one bubble, then add with forwarded r5
    drive(i_ins(6'h23, 5'd1, 5'd5, 16'h0004), 1'b1, 1'b0, 1'b0);
    cycle("lw");
    drive(r_ins(5'd5, 5'd7, 5'd6, 6'h20), 1'b1, 1'b0, 1'b0);
    #1;
    chk("lu_idstall", EXW'(IdStall), EXW'(1'b1));
    cycle("lu_bubble");
    chk("lu_bubble_valid", EXW'(ExValid), '0);
    wb(1'b1, 5'd5, 32'hCAFE);
    cycle("lu_issue");
    chk("lu_fwd_a", EXW'(ExA), EXW'(32'hCAFE));
    wb(1'b0, 5'd0, 32'h0);

    // 4. immediates and write-enable decode
    drive(i_ins(6'h08, 5'd1, 5'd2, 16'hFFF0), 1'b1, 1'b0, 1'b0);
    cycle("addi");
    chk("addi_imm", EXW'(ExImm), EXW'(32'hFFFF_FFF0));
    drive(i_ins(6'h0D, 5'd1, 5'd2, 16'hFFF0), 1'b1, 1'b0, 1'b0);
    cycle("ori");
    chk("ori_imm", EXW'(ExImm), EXW'(32'h0000_FFF0));
    drive(i_ins(6'h0F, 5'd0, 5'd4, 16'h1234), 1'b1, 1'b0, 1'b0);
    cycle("lui");
    chk("lui_imm", EXW'(ExImm), EXW'(32'h1234_0000));
    drive(i_ins(6'h2B, 5'd1, 5'd9, 16'h0008), 1'b1, 1'b0, 1'b0);
    cycle("sw");
    chk("sw_wren", EXW'(ExWrEn), '0);
    drive(r_ins(5'd1, 5'd2, 5'd0, 6'h20), 1'b1, 1'b0, 1'b0);
    cycle("add_r0");
    drive(i_ins(6'h20, 5'd3, 5'd8, 16'h8001), 1'b1, 1'b0, 1'b0);
    cycle("lb");
    drive(i_ins(6'h0C, 5'd2, 5'd9, 16'h8001), 1'b0, 1'b0, 1'b0);
    cycle("andi_invalid");

    // 5. ExStall hold for 3 cycles, then Flush during stall
    drive(i_ins(6'h08, 5'd4, 5'd16, 16'h0010), 1'b1, 1'b0, 1'b0);
    cycle("pre_stall");
    for (int k = 0; k < 3; k++) begin
      drive(i_ins(6'h08, 5'd5, 5'd17, 16'(k)), 1'b1, 1'b1, 1'b0);
      cycle($sformatf("stall%0d", k));
    end
    chk("stall_held_wa", EXW'(ExWrAddr), EXW'(5'd16));
    drive(i_ins(6'h08, 5'd5, 5'd17, 16'h0003), 1'b1, 1'b1, 1'b1);
    cycle("flush_in_stall");
    chk("flush_valid", EXW'(ExValid), '0);
    drive(i_ins(6'h08, 5'd5, 5'd17, 16'h0003), 1'b1, 1'b0, 1'b0);
    cycle("post_flush");

    // 6. asynchronous reset between edges, then resume
    #3;
    Rst_n = 1'b0;
    #1;
    chk("midreset_ex", ex_obs(), '0);
    m = '0;
    #2;
    Rst_n = 1'b1;
    drive(r_ins(5'd20, 5'd21, 5'd22, 6'h24), 1'b1, 1'b0, 1'b0);
    cycle("resume");

    // randomised traffic through the same scoreboard
    for (int n = 0; n < 60; n++) begin
      drive({op_tab[$urandom_range(0, 9)], 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
             16'($urandom)},
            1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) == 0),
            1'($urandom_range(0, 7) == 0));
      wb(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom);
      cycle($sformatf("rand%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard time limit so the bench always terminates.
  initial begin
    #100000;
    errors++;
    $display("FAIL timeout observed=running expected=finished");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
